// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction decode stage.
package decode_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_IDX_W  = 4;
  localparam int unsigned NR_REG_DEF = 16;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BRU = 2'd1,
    FU_LSU = 2'd2,
    FU_CSR = 2'd3
  } fu_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_t;

  // Major opcodes, inst[6:2]; inst[1:0] must be 2'b11.
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // True when a 5-bit register field names a register this core lacks.
  function automatic logic reg_oob(input logic [4:0] idx, input int unsigned nr);
    return 32'(idx) >= nr;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Busy-bit scoreboard for in-flight destination registers; x0 never busy.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int unsigned NR_REG = NR_REG_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_valid,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_valid,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic                 q_rs1_en,
  input  logic [REG_IDX_W-1:0] q_rs1_idx,
  input  logic                 q_rs2_en,
  input  logic [REG_IDX_W-1:0] q_rs2_idx,
  input  logic                 q_rd_en,
  input  logic [REG_IDX_W-1:0] q_rd_idx,
  output logic                 rs1_busy_c,
  output logic                 rs2_busy_c,
  output logic                 rd_busy_c
);

  logic [NR_REG-1:0] busy;
  logic [NR_REG-1:0] busy_nxt;

  // Clear first so a same-cycle set on the same index wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_valid) busy_nxt[clr_idx] = 1'b0;
    if (set_valid) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign rs1_busy_c = q_rs1_en & busy[q_rs1_idx];
  assign rs2_busy_c = q_rs2_en & busy[q_rs2_idx];
  assign rd_busy_c  = q_rd_en  & busy[q_rd_idx];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry holding register, RV32E decode, operand read and
// scoreboard-based RAW/WAW interlock between fetch and execute.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned NR_REG = NR_REG_DEF,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_inst,
  input  logic                 jump_flush,
  input  logic                 cs_flush,
  output logic [REG_IDX_W-1:0] rs1_addr,
  output logic [REG_IDX_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_src1,
  output logic [XLEN-1:0]      out_src2,
  output logic [XLEN-1:0]      out_imm,
  output logic [REG_IDX_W-1:0] out_rd,
  output fu_t                  out_fu,
  output logic [3:0]           out_funct,
  output logic                 out_fencei,
  output logic                 out_illegal
);

  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] inst_r;

  logic [4:0] opcode, rd_f, rs1_f, rs2_f;
  logic [2:0] funct3;
  logic       opc_known, uses_rs1, uses_rs2, writes_rd, is_illegal;
  logic       flush, stall, issue;
  logic       rs1_busy, rs2_busy, rd_busy;
  imm_t       imm_sel;
  fu_t        fu;

  assign opcode = inst_r[6:2];
  assign rd_f   = inst_r[11:7];
  assign funct3 = inst_r[14:12];
  assign rs1_f  = inst_r[19:15];
  assign rs2_f  = inst_r[24:20];

  // Opcode classification: operand usage, immediate form, functional unit.
  always_comb begin
    opc_known = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    imm_sel   = IMM_NONE;
    fu        = FU_ALU;
    if (inst_r[1:0] == 2'b11) begin
      opc_known = 1'b1;
      case (opcode)
        OPC_LUI, OPC_AUIPC: begin writes_rd = 1'b1; imm_sel = IMM_U; end
        OPC_JAL:      begin writes_rd = 1'b1; imm_sel = IMM_J; fu = FU_BRU; end
        OPC_JALR:     begin writes_rd = 1'b1; uses_rs1 = 1'b1; imm_sel = IMM_I; fu = FU_BRU; end
        OPC_BRANCH:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_sel = IMM_B; fu = FU_BRU; end
        OPC_LOAD:     begin writes_rd = 1'b1; uses_rs1 = 1'b1; imm_sel = IMM_I; fu = FU_LSU; end
        OPC_STORE:    begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_sel = IMM_S; fu = FU_LSU; end
        OPC_OP_IMM:   begin writes_rd = 1'b1; uses_rs1 = 1'b1; imm_sel = IMM_I; end
        OPC_OP:       begin writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
        OPC_SYSTEM:   begin writes_rd = 1'b1; uses_rs1 = ~funct3[2]; imm_sel = IMM_I; fu = FU_CSR; end
        OPC_MISC_MEM: imm_sel = IMM_I;
        default:      opc_known = 1'b0;
      endcase
    end
  end

  assign is_illegal = ~opc_known
                    | (uses_rs1  & reg_oob(rs1_f, NR_REG))
                    | (uses_rs2  & reg_oob(rs2_f, NR_REG))
                    | (writes_rd & reg_oob(rd_f,  NR_REG));

  always_comb begin
    case (imm_sel)
      IMM_I:   out_imm = {{20{inst_r[31]}}, inst_r[31:20]};
      IMM_S:   out_imm = {{20{inst_r[31]}}, inst_r[31:25], inst_r[11:7]};
      IMM_B:   out_imm = {{19{inst_r[31]}}, inst_r[31], inst_r[7], inst_r[30:25], inst_r[11:8], 1'b0};
      IMM_U:   out_imm = {inst_r[31:12], 12'h000};
      IMM_J:   out_imm = {{11{inst_r[31]}}, inst_r[31], inst_r[19:12], inst_r[20], inst_r[30:21], 1'b0};
      default: out_imm = '0;
    endcase
  end

  assign rs1_addr    = rs1_f[REG_IDX_W-1:0];
  assign rs2_addr    = rs2_f[REG_IDX_W-1:0];
  assign out_rd      = (writes_rd & ~is_illegal) ? rd_f[REG_IDX_W-1:0] : '0;
  assign out_pc      = pc_r;
  assign out_src1    = rs1_data;
  assign out_src2    = rs2_data;
  assign out_fu      = fu;
  assign out_funct   = {inst_r[30], funct3};
  assign out_fencei  = opc_known & (opcode == OPC_MISC_MEM) & (funct3 == 3'b001);
  assign out_illegal = is_illegal;

  // Illegal instructions bypass the interlock; their rd is already zero.
  decode_scoreboard #(.NR_REG(NR_REG)) u_sb (
    .clock      (clock),
    .reset      (reset),
    .set_valid  (issue & (out_rd != '0)),
    .set_idx    (out_rd),
    .clr_valid  (wb_valid),
    .clr_idx    (wb_rd),
    .q_rs1_en   (uses_rs1 & ~is_illegal),
    .q_rs1_idx  (rs1_addr),
    .q_rs2_en   (uses_rs2 & ~is_illegal),
    .q_rs2_idx  (rs2_addr),
    .q_rd_en    (out_rd != '0),
    .q_rd_idx   (out_rd),
    .rs1_busy_c (rs1_busy),
    .rs2_busy_c (rs2_busy),
    .rd_busy_c  (rd_busy)
  );

  assign flush     = jump_flush | cs_flush;
  assign stall     = valid_r & (rs1_busy | rs2_busy | rd_busy);
  assign out_valid = valid_r & ~stall & ~flush;
  assign issue     = out_valid & out_ready;
  assign in_ready  = ~flush & (~valid_r | issue);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= 1'b0;
      pc_r    <= RST_PC;
      inst_r  <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (in_valid & in_ready) begin
      valid_r <= 1'b1;
      pc_r    <= in_pc;
      inst_r  <= in_inst;
    end else if (issue) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a behavioural decode/scoreboard model.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        jump_flush, cs_flush;
  logic [3:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_src1, out_src2, out_imm;
  logic [3:0]  out_rd;
  fu_t         out_fu;
  logic [3:0]  out_funct;
  logic        out_fencei, out_illegal;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] rf [16];

  always #5 clock = ~clock;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  decode_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .jump_flush(jump_flush), .cs_flush(cs_flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
    .out_rd(out_rd), .out_fu(out_fu), .out_funct(out_funct), .out_fencei(out_fencei),
    .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic        legal;
    fu_t         fu;
    logic [31:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        u1;
    logic        u2;
    logic        fencei;
  } dec_t;

  // Reference decode from full 7-bit opcodes; immediates built arithmetically.
  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    logic signed [31:0] s;
    logic w, known;
    s = i; w = 1'b0; known = 1'b1;
    d = '0; d.fu = FU_ALU;
    case (i[6:0])
      7'h37, 7'h17: begin w = 1'b1; d.imm = i & 32'hFFFFF000; end
      7'h6F: begin
        w = 1'b1; d.fu = FU_BRU;
        d.imm = 32'(s >>> 31) * 32'h100000 + 32'(i[19:12]) * 32'd4096
              + 32'(i[20]) * 32'd2048 + 32'(i[30:21]) * 32'd2;
      end
      7'h67: begin w = 1'b1; d.u1 = 1'b1; d.fu = FU_BRU; d.imm = s >>> 20; end
      7'h63: begin
        d.u1 = 1'b1; d.u2 = 1'b1; d.fu = FU_BRU;
        d.imm = 32'(s >>> 31) * 32'd4096 + 32'(i[7]) * 32'd2048
              + 32'(i[30:25]) * 32'd32 + 32'(i[11:8]) * 32'd2;
      end
      7'h03: begin w = 1'b1; d.u1 = 1'b1; d.fu = FU_LSU; d.imm = s >>> 20; end
      7'h23: begin
        d.u1 = 1'b1; d.u2 = 1'b1; d.fu = FU_LSU;
        d.imm = 32'(s >>> 25) * 32'd32 + 32'(i[11:7]);
      end
      7'h13: begin w = 1'b1; d.u1 = 1'b1; d.imm = s >>> 20; end
      7'h33: begin w = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
      7'h73: begin w = 1'b1; d.u1 = ~i[14]; d.fu = FU_CSR; d.imm = s >>> 20; end
      7'h0F: d.imm = s >>> 20;
      default: known = 1'b0;
    endcase
    d.legal  = known && !(d.u1 && i[19:15] >= 5'd16) && !(d.u2 && i[24:20] >= 5'd16)
                     && !(w && i[11:7] >= 5'd16);
    d.rd     = (w && d.legal) ? i[10:7] : 4'd0;
    d.rs1    = i[18:15];
    d.rs2    = i[23:20];
    d.fencei = known && (i[6:0] == 7'h0F) && (i[14:12] == 3'b001);
    return d;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 11))
      0: i[6:0] = 7'h37;  1: i[6:0] = 7'h17;  2: i[6:0] = 7'h6F;
      3: i[6:0] = 7'h67;  4: i[6:0] = 7'h63;  5: i[6:0] = 7'h03;
      6: i[6:0] = 7'h23;  7: i[6:0] = 7'h13;  8: i[6:0] = 7'h33;
      9: i[6:0] = 7'h73; 10: i[6:0] = 7'h0F;
      default: ;
    endcase
    i[11:7]  = 5'($urandom_range(0, 7)) + (($urandom_range(0, 15) == 0) ? 5'd16 : 5'd0);
    i[19:15] = 5'($urandom_range(0, 7)) + (($urandom_range(0, 15) == 0) ? 5'd16 : 5'd0);
    i[24:20] = 5'($urandom_range(0, 7)) + (($urandom_range(0, 15) == 0) ? 5'd16 : 5'd0);
    return i;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_pc = '0; in_inst = '0; jump_flush = 1'b0; cs_flush = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    vectors += 4;
    if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b exp 0", out_valid); errors++; end
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b exp 1", in_ready); errors++; end
    if (out_pc !== 32'h0) begin $display("FAIL reset_pc got %h exp 00000000", out_pc); errors++; end
    if (dut.u_sb.busy !== 16'h0) begin $display("FAIL reset_busy got %h exp 0000", dut.u_sb.busy); errors++; end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0050_0093; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin $display("FAIL addi_in_ready got %b exp 1", in_ready); errors++; end
    tick(); in_valid = 1'b0; #1;
    vectors += 6;
    if (out_valid !== 1'b1) begin $display("FAIL addi_valid got %b exp 1", out_valid); errors++; end
    if (out_pc !== 32'h8000_0000) begin $display("FAIL addi_pc got %h exp 80000000", out_pc); errors++; end
    if (out_imm !== 32'd5) begin $display("FAIL addi_imm got %h exp 5", out_imm); errors++; end
    if (out_rd !== 4'd1) begin $display("FAIL addi_rd got %0d exp 1", out_rd); errors++; end
    if (out_fu !== FU_ALU) begin $display("FAIL addi_fu got %0d exp %0d", out_fu, FU_ALU); errors++; end
    if (out_illegal !== 1'b0) begin $display("FAIL addi_illegal got %b exp 0", out_illegal); errors++; end
    tick(); #1;
    vectors += 2;
    if (dut.u_sb.busy[1] !== 1'b1) begin $display("FAIL addi_busy1 got %b exp 1", dut.u_sb.busy[1]); errors++; end
    if (out_valid !== 1'b0) begin $display("FAIL addi_drained got %b exp 0", out_valid); errors++; end
  endtask

  // ADD x2,x1,x1 waits on x1 (left busy by test_addi) until writeback.
  task automatic test_raw_stall();
    in_valid = 1'b1; in_pc = 32'h8000_0004; in_inst = 32'h0010_8133; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors += 2;
      if (out_valid !== 1'b0) begin $display("FAIL raw_stall_valid cyc%0d got %b exp 0", k, out_valid); errors++; end
      if (in_ready !== 1'b0) begin $display("FAIL raw_stall_ready cyc%0d got %b exp 0", k, in_ready); errors++; end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 4'd1; #1;
    vectors++;
    if (out_valid !== 1'b0) begin $display("FAIL raw_wb_cycle got %b exp 0", out_valid); errors++; end
    tick(); wb_valid = 1'b0; #1;
    vectors += 4;
    if (out_valid !== 1'b1) begin $display("FAIL raw_release got %b exp 1", out_valid); errors++; end
    if (out_src1 !== rf[1]) begin $display("FAIL raw_src1 got %h exp %h", out_src1, rf[1]); errors++; end
    if (out_src2 !== rf[1]) begin $display("FAIL raw_src2 got %h exp %h", out_src2, rf[1]); errors++; end
    if (out_rd !== 4'd2) begin $display("FAIL raw_rd got %0d exp 2", out_rd); errors++; end
    tick(); wb_valid = 1'b1; wb_rd = 4'd2;
    tick(); wb_valid = 1'b0; #1;
    vectors++;
    if (dut.u_sb.busy !== 16'h0) begin $display("FAIL raw_clean got %h exp 0000", dut.u_sb.busy); errors++; end
  endtask

  task automatic test_branch();
    in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'hFE00_0CE3; out_ready = 1'b1;
    tick(); in_valid = 1'b0; #1;
    vectors += 4;
    if (out_valid !== 1'b1) begin $display("FAIL beq_valid got %b exp 1", out_valid); errors++; end
    if (out_imm !== 32'hFFFF_FFF8) begin $display("FAIL beq_imm got %h exp fffffff8", out_imm); errors++; end
    if (out_rd !== 4'd0) begin $display("FAIL beq_rd got %0d exp 0", out_rd); errors++; end
    if (out_fu !== FU_BRU) begin $display("FAIL beq_fu got %0d exp %0d", out_fu, FU_BRU); errors++; end
    tick(); #1;
    vectors++;
    if (dut.u_sb.busy !== 16'h0) begin $display("FAIL beq_busy got %h exp 0000", dut.u_sb.busy); errors++; end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h0070_0213; out_ready = 1'b0;
    tick(); in_valid = 1'b0; #1;
    vectors++;
    if (out_valid !== 1'b1) begin $display("FAIL flush_held got %b exp 1", out_valid); errors++; end
    tick(); #1;
    vectors += 2;
    if (out_valid !== 1'b1) begin $display("FAIL flush_hold2 got %b exp 1", out_valid); errors++; end
    if (out_pc !== 32'h100) begin $display("FAIL flush_stable_pc got %h exp 00000100", out_pc); errors++; end
    jump_flush = 1'b1; in_valid = 1'b1; in_pc = 32'h200; in_inst = 32'h0010_0293; #1;
    vectors += 2;
    if (out_valid !== 1'b0) begin $display("FAIL flush_gate_valid got %b exp 0", out_valid); errors++; end
    if (in_ready !== 1'b0) begin $display("FAIL flush_gate_ready got %b exp 0", in_ready); errors++; end
    tick(); jump_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    vectors += 3;
    if (out_valid !== 1'b0) begin $display("FAIL flush_after_valid got %b exp 0", out_valid); errors++; end
    if (in_ready !== 1'b1) begin $display("FAIL flush_after_ready got %b exp 1", in_ready); errors++; end
    if (dut.u_sb.busy !== 16'h0) begin $display("FAIL flush_busy got %h exp 0000", dut.u_sb.busy); errors++; end
  endtask

  task automatic test_illegal();
    logic [31:0] insts [2];
    insts[0] = 32'h0000_0000;
    insts[1] = 32'h0010_0893;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_pc = 32'h300; in_inst = insts[k];
      tick(); in_valid = 1'b0; #1;
      vectors += 3;
      if (out_valid !== 1'b1) begin $display("FAIL illegal%0d_valid got %b exp 1", k, out_valid); errors++; end
      if (out_illegal !== 1'b1) begin $display("FAIL illegal%0d_flag got %b exp 1", k, out_illegal); errors++; end
      if (out_rd !== 4'd0) begin $display("FAIL illegal%0d_rd got %0d exp 0", k, out_rd); errors++; end
      tick(); #1;
      vectors++;
      if (dut.u_sb.busy !== 16'h0) begin $display("FAIL illegal%0d_busy got %h exp 0000", k, dut.u_sb.busy); errors++; end
    end
  endtask

  task automatic test_set_clear_same();
    in_valid = 1'b1; in_pc = 32'h400; in_inst = 32'h0010_0193; out_ready = 1'b1;
    tick(); in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 4'd3; #1;
    vectors++;
    if (out_valid !== 1'b1) begin $display("FAIL setclr_valid got %b exp 1", out_valid); errors++; end
    tick(); wb_valid = 1'b0; #1;
    vectors++;
    if (dut.u_sb.busy[3] !== 1'b1) begin $display("FAIL setclr_busy3 got %b exp 1", dut.u_sb.busy[3]); errors++; end
    wb_valid = 1'b1; wb_rd = 4'd3;
    tick(); wb_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; in_pc = 32'h500; in_inst = 32'h0010_0293; out_ready = 1'b1;
    tick(); in_inst = 32'h0052_8333; in_pc = 32'h504;
    tick(); in_valid = 1'b0; #1;
    vectors++;
    if (out_valid !== 1'b0) begin $display("FAIL rststall_stalled got %b exp 0", out_valid); errors++; end
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    vectors += 3;
    if (out_valid !== 1'b0) begin $display("FAIL rststall_valid got %b exp 0", out_valid); errors++; end
    if (in_ready !== 1'b1) begin $display("FAIL rststall_ready got %b exp 1", in_ready); errors++; end
    if (dut.u_sb.busy !== 16'h0) begin $display("FAIL rststall_busy got %h exp 0000", dut.u_sb.busy); errors++; end
  endtask

  task automatic test_random(input int cycles);
    logic        m_valid;
    logic [31:0] m_pc, m_inst;
    logic [15:0] m_busy;
    logic        fl, st, e_ov, e_ir;
    dec_t        d;
    idle(); reset = 1'b1;
    tick(); reset = 1'b0;
    m_valid = 1'b0; m_pc = '0; m_inst = '0; m_busy = '0;
    for (int c = 0; c < cycles; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_pc      = $urandom & 32'hFFFF_FFFC;
      in_inst    = gen_inst();
      out_ready  = ($urandom_range(0, 3) != 0);
      jump_flush = ($urandom_range(0, 19) == 0);
      cs_flush   = ($urandom_range(0, 29) == 0);
      wb_valid   = ($urandom_range(0, 2) == 0);
      wb_rd      = 4'($urandom_range(0, 7));
      #1;
      d    = ref_decode(m_inst);
      fl   = jump_flush | cs_flush;
      st   = m_valid && d.legal && ((d.u1 && m_busy[d.rs1]) || (d.u2 && m_busy[d.rs2]) ||
                                    (d.rd != 0 && m_busy[d.rd]));
      e_ov = m_valid && !st && !fl;
      e_ir = !fl && (!m_valid || (e_ov && out_ready));
      vectors += 3;
      if (out_valid !== e_ov) begin $display("FAIL rnd_valid cyc%0d got %b exp %b", c, out_valid, e_ov); errors++; end
      if (in_ready !== e_ir) begin $display("FAIL rnd_ready cyc%0d got %b exp %b", c, in_ready, e_ir); errors++; end
      if (dut.u_sb.busy !== m_busy) begin $display("FAIL rnd_busy cyc%0d got %h exp %h", c, dut.u_sb.busy, m_busy); errors++; end
      if (e_ov) begin
        vectors += 4;
        if (out_pc !== m_pc) begin $display("FAIL rnd_pc cyc%0d got %h exp %h", c, out_pc, m_pc); errors++; end
        if (out_imm !== d.imm) begin $display("FAIL rnd_imm cyc%0d inst %h got %h exp %h", c, m_inst, out_imm, d.imm); errors++; end
        if ({out_src1, out_src2} !== {rf[d.rs1], rf[d.rs2]}) begin
          $display("FAIL rnd_src cyc%0d got %h/%h exp %h/%h", c, out_src1, out_src2, rf[d.rs1], rf[d.rs2]); errors++;
        end
        if ({out_rd, out_fu, out_funct, out_fencei, out_illegal} !==
            {d.rd, d.fu, m_inst[30], m_inst[14:12], d.fencei, ~d.legal}) begin
          $display("FAIL rnd_ctrl cyc%0d inst %h got rd%0d fu%0d f%h fi%b il%b exp rd%0d fu%0d fi%b il%b",
                   c, m_inst, out_rd, out_fu, out_funct, out_fencei, out_illegal, d.rd, d.fu, d.fencei, ~d.legal);
          errors++;
        end
      end
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (e_ov && out_ready && d.rd != 0) m_busy[d.rd] = 1'b1;
      if (fl) m_valid = 1'b0;
      else if (in_valid && e_ir) begin m_valid = 1'b1; m_pc = in_pc; m_inst = in_inst; end
      else if (e_ov && out_ready) m_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rf[r] = $urandom;
    test_reset();
    test_addi();
    test_raw_stall();
    test_branch();
    test_flush();
    test_illegal();
    test_set_clear_same();
    test_reset_mid_stall();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
